// File: rtl/vscale_wb_stage_if.sv
// X/WB boundary bundle: X-stage capture inputs, dmem/mul-div responses and
// register-file writeback outputs of vscale_wb_stage.
interface vscale_wb_stage_if #(
   parameter int XPR_LEN        = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      ex_valid;
   logic                      kill_X;
   logic [XPR_LEN-1:0]        alu_out;
   logic [REG_ADDR_WIDTH-1:0] rd_X;
   logic                      wen_X;
   logic [1:0]                wb_src_sel_X;
   logic [2:0]                mem_type_X;
   logic [XPR_LEN-1:0]        csr_rdata;
   logic                      dmem_resp_valid;
   logic [XPR_LEN-1:0]        dmem_rdata;
   logic                      md_resp_valid;
   logic [XPR_LEN-1:0]        md_resp_result;
   logic                      stall_WB;
   logic                      wb_wen;
   logic [REG_ADDR_WIDTH-1:0] wb_rd;
   logic [XPR_LEN-1:0]        wb_data;
   logic                      bypass_valid;
   logic                      retire;
   logic                      exception_WB;

   modport slave (
      input  ex_valid, kill_X, alu_out, rd_X, wen_X, wb_src_sel_X, mem_type_X,
             csr_rdata, dmem_resp_valid, dmem_rdata, md_resp_valid, md_resp_result,
      output stall_WB, wb_wen, wb_rd, wb_data, bypass_valid, retire, exception_WB
   );

   modport master (
      output ex_valid, kill_X, alu_out, rd_X, wen_X, wb_src_sel_X, mem_type_X,
             csr_rdata, dmem_resp_valid, dmem_rdata, md_resp_valid, md_resp_result,
      input  stall_WB, wb_wen, wb_rd, wb_data, bypass_valid, retire, exception_WB
   );
endinterface

// File: rtl/vscale_wb_stage.sv
// Writeback stage: registers X results, waits for dmem/mul-div responses, aligns loads.
// Optional misaligned-load exception enabled by defining VSCALE_WB_MISALIGN_CHECK_EN.
module vscale_wb_stage #(
   parameter int XPR_LEN        = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input logic              clk,
   input logic              reset,
   vscale_wb_stage_if.slave wb
);
   typedef enum logic [1:0] {S_IDLE, S_DONE, S_WAIT} state_t;

   typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_CSR = 2'd2, SRC_MD = 2'd3} src_t;

   typedef enum logic [2:0] {
      MT_B = 3'd0, MT_H = 3'd1, MT_W = 3'd2, MT_BU = 3'd4, MT_HU = 3'd5
   } mem_t;

   state_t                    state, next_state;
   logic [XPR_LEN-1:0]        alu_q, csr_q;
   logic [REG_ADDR_WIDTH-1:0] rd_q;
   logic                      wen_q;
   logic [1:0]                sel_q;
   logic [2:0]                mt_q;
   logic                      resp_match, result_avail, stall, exc, misaligned_X;
   logic [7:0]                ld_byte;
   logic [15:0]               ld_half;
   logic [XPR_LEN-1:0]        load_data, data_mux;

`ifdef VSCALE_WB_MISALIGN_CHECK_EN
   logic misaligned_q;

   always_comb begin
      misaligned_X = 1'b0;
      if (wb.wb_src_sel_X == SRC_MEM) begin
         case (wb.mem_type_X)
            MT_B, MT_BU: misaligned_X = 1'b0;
            MT_H, MT_HU: misaligned_X = wb.alu_out[0];
            default:     misaligned_X = |wb.alu_out[1:0];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       misaligned_q <= 1'b0;
      else if (!stall) misaligned_q <= misaligned_X;
   end

   // A misaligned load retires nothing; it only flags the exception while in DONE.
   assign exc = (state == S_DONE) && misaligned_q;
`else
   assign misaligned_X = 1'b0;
   assign exc          = 1'b0;
`endif

   always_comb begin
      next_state = state;
      if (!stall) begin
         if (wb.ex_valid && !wb.kill_X) begin
            if ((wb.wb_src_sel_X == SRC_MEM || wb.wb_src_sel_X == SRC_MD) && !misaligned_X)
               next_state = S_WAIT;
            else
               next_state = S_DONE;
         end else begin
            next_state = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_q <= '0;
         csr_q <= '0;
         rd_q  <= '0;
         wen_q <= 1'b0;
         sel_q <= '0;
         mt_q  <= '0;
      end else if (!stall) begin
         alu_q <= wb.alu_out;
         csr_q <= wb.csr_rdata;
         rd_q  <= wb.rd_X;
         wen_q <= wb.wen_X;
         sel_q <= wb.wb_src_sel_X;
         mt_q  <= wb.mem_type_X;
      end
   end

   // Only the response type the held instruction is waiting for counts.
   always_comb begin
      resp_match = 1'b0;
      case (sel_q)
         SRC_MEM: resp_match = wb.dmem_resp_valid;
         SRC_MD:  resp_match = wb.md_resp_valid;
         default: resp_match = 1'b0;
      endcase
   end

   assign stall        = (state == S_WAIT) && !resp_match;
   assign result_avail = (state == S_DONE) || ((state == S_WAIT) && resp_match);

   always_comb begin
      ld_half = alu_q[1] ? wb.dmem_rdata[31:16] : wb.dmem_rdata[15:0];
      ld_byte = alu_q[0] ? ld_half[15:8] : ld_half[7:0];
      case (mt_q)
         MT_B:    load_data = {{(XPR_LEN-8){ld_byte[7]}}, ld_byte};
         MT_BU:   load_data = {{(XPR_LEN-8){1'b0}}, ld_byte};
         MT_H:    load_data = {{(XPR_LEN-16){ld_half[15]}}, ld_half};
         MT_HU:   load_data = {{(XPR_LEN-16){1'b0}}, ld_half};
         default: load_data = wb.dmem_rdata;
      endcase
   end

   always_comb begin
      data_mux = alu_q;
      case (sel_q)
         SRC_MEM: data_mux = load_data;
         SRC_CSR: data_mux = csr_q;
         SRC_MD:  data_mux = wb.md_resp_result;
         default: data_mux = alu_q;
      endcase
   end

   assign wb.stall_WB     = stall;
   assign wb.wb_wen       = result_avail && wen_q && (rd_q != '0) && !exc;
   assign wb.wb_rd        = rd_q;
   assign wb.wb_data      = data_mux;
   assign wb.bypass_valid = wb.wb_wen;
   assign wb.retire       = result_avail && !exc;
   assign wb.exception_WB = exc;
endmodule

// File: tb/tb_vscale_wb_stage.sv
// Randomized scoreboard bench for vscale_wb_stage against a behavioural writeback model.
module tb_vscale_wb_stage;
   localparam int XL = 32;
   localparam int RW = 5;

   typedef struct {
      logic        ex;
      logic        kill;
      logic [1:0]  sel;
      logic [2:0]  mt;
      logic [31:0] addr;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] csr;
      logic [31:0] resp;
      int unsigned delay;
   } instr_t;

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   exp_t        sb[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   vscale_wb_stage_if #(.XPR_LEN(XL), .REG_ADDR_WIDTH(RW)) bus ();

   vscale_wb_stage #(.XPR_LEN(XL), .REG_ADDR_WIDTH(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic is_misaligned(input instr_t in);
`ifdef VSCALE_WB_MISALIGN_CHECK_EN
      if (in.sel != 2'd1) return 1'b0;
      case (in.mt)
         3'd0, 3'd4: return 1'b0;
         3'd1, 3'd5: return (in.addr % 2) != 0;
         default:    return (in.addr % 4) != 0;
      endcase
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] mt, input logic [31:0] addr,
                                              input logic [31:0] w);
      int unsigned off;
      logic [31:0] v;
      off = addr % 4;
      case (mt)
         3'd0, 3'd4: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (mt == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (mt == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] result_of(input instr_t in);
      case (in.sel)
         2'd0:    return in.addr;
         2'd1:    return load_value(in.mt, in.addr, in.resp);
         2'd2:    return in.csr;
         default: return in.resp;
      endcase
   endfunction

   function automatic instr_t mk(input logic ex, input logic kill, input logic [1:0] sel,
                                 input logic [2:0] mt, input logic [31:0] addr, input logic [4:0] rd,
                                 input logic wen, input logic [31:0] resp, input int unsigned delay);
      instr_t in;
      in.ex = ex; in.kill = kill; in.sel = sel; in.mt = mt; in.addr = addr;
      in.rd = rd; in.wen = wen; in.csr = $urandom; in.resp = resp; in.delay = delay;
      return in;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, bus.stall_WB, 0);
      chk({tag, "_wen"}, bus.wb_wen, 0);
      chk({tag, "_rd"}, bus.wb_rd, 0);
      chk({tag, "_data"}, bus.wb_data, 0);
      chk({tag, "_bypass"}, bus.bypass_valid, 0);
      chk({tag, "_retire"}, bus.retire, 0);
      chk({tag, "_exc"}, bus.exception_WB, 0);
   endtask

   // Presents one X instruction, captures it, then (if it waits) plays the response
   // after in.delay stall cycles; the response stays asserted until the next capture.
   task automatic run_instr(input instr_t in);
      logic valid, exc, waits;
      valid = in.ex && !in.kill;
      exc   = valid && is_misaligned(in);
      waits = valid && (in.sel == 2'd1 || in.sel == 2'd3) && !exc;
      bus.ex_valid = in.ex;   bus.kill_X = in.kill;  bus.alu_out = in.addr;
      bus.rd_X = in.rd;       bus.wen_X = in.wen;    bus.wb_src_sel_X = in.sel;
      bus.mem_type_X = in.mt; bus.csr_rdata = in.csr;
      if (valid && !exc) sb.push_back('{wen: in.wen && (in.rd != 0), rd: in.rd, data: result_of(in)});
      @(posedge clk); #1;
      bus.dmem_resp_valid = 1'b0;
      bus.md_resp_valid   = 1'b0;
      if (!waits) begin
         chk("retire_latency", bus.retire, valid && !exc);
         chk("no_stall", bus.stall_WB, 0);
         chk("exception", bus.exception_WB, exc);
      end else begin
         for (int unsigned k = 0; k < in.delay; k++) begin
            bus.ex_valid = 1'($urandom); bus.kill_X = 1'($urandom);
            bus.alu_out = $urandom;      bus.wb_src_sel_X = 2'($urandom);
            bus.dmem_rdata = $urandom;   bus.md_resp_result = $urandom;
            if (in.sel == 2'd1) bus.md_resp_valid = 1'($urandom);
            else                bus.dmem_resp_valid = 1'($urandom);
            #1;
            chk("wait_stall", bus.stall_WB, 1);
            chk("wait_retire", bus.retire, 0);
            chk("wait_wen", bus.wb_wen, 0);
            @(posedge clk); #1;
         end
         bus.dmem_resp_valid = 1'b0;
         bus.md_resp_valid   = 1'b0;
         if (in.sel == 2'd1) begin
            bus.dmem_resp_valid = 1'b1; bus.dmem_rdata = in.resp;
         end else begin
            bus.md_resp_valid = 1'b1;   bus.md_resp_result = in.resp;
         end
         #1;
         chk("resp_stall", bus.stall_WB, 0);
         chk("resp_retire", bus.retire, 1);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         chk("bypass_eq_wen", bus.bypass_valid, bus.wb_wen);
         if (bus.retire === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_retire: got retire=1, expected no pending instruction at %0t", $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_wen", bus.wb_wen, e.wen);
               if (e.wen) begin
                  chk("sb_rd", bus.wb_rd, e.rd);
                  chk("sb_data", bus.wb_data, e.data);
               end
            end
         end else begin
            chk("wen_without_retire", bus.wb_wen, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t in;
      reset = 1'b1;
      bus.ex_valid = 0; bus.kill_X = 0; bus.alu_out = '0; bus.rd_X = '0; bus.wen_X = 0;
      bus.wb_src_sel_X = '0; bus.mem_type_X = '0; bus.csr_rdata = '0;
      bus.dmem_resp_valid = 0; bus.dmem_rdata = '0; bus.md_resp_valid = 0; bus.md_resp_result = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("in_reset");
      reset = 1'b0;
      #1;
      check_all_zero("after_release");

      run_instr(mk(1, 0, 2'd0, 3'd2, 32'h1234_5678, 5'd5, 1, 0, 0));
      chk("alu_wen", bus.wb_wen, 1);
      chk("alu_rd", bus.wb_rd, 5);
      chk("alu_data", bus.wb_data, 32'h1234_5678);
      run_instr(mk(1, 0, 2'd1, 3'd0, 32'h0000_1003, 5'd7, 1, 32'h80FF_0011, 2));
      chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
      run_instr(mk(1, 0, 2'd1, 3'd4, 32'h0000_1003, 5'd7, 1, 32'h80FF_0011, 2));
      chk("lbu_data", bus.wb_data, 32'h0000_0080);
      run_instr(mk(1, 0, 2'd1, 3'd5, 32'h0000_2002, 5'd9, 1, 32'hBEEF_1234, 0));
      chk("lhu_data", bus.wb_data, 32'h0000_BEEF);
      run_instr(mk(1, 0, 2'd1, 3'd1, 32'h0000_2002, 5'd9, 1, 32'hBEEF_1234, 1));
      chk("lh_data", bus.wb_data, 32'hFFFF_BEEF);
      run_instr(mk(1, 1, 2'd0, 3'd2, 32'hDEAD_BEEF, 5'd3, 1, 0, 0));
      chk("kill_wen", bus.wb_wen, 0);
      run_instr(mk(1, 0, 2'd0, 3'd2, 32'h0000_0042, 5'd0, 1, 0, 0));
      chk("rd0_wen", bus.wb_wen, 0);
      chk("rd0_retire", bus.retire, 1);
`ifdef VSCALE_WB_MISALIGN_CHECK_EN
      run_instr(mk(1, 0, 2'd1, 3'd2, 32'h0000_2002, 5'd4, 1, 32'h1111_2222, 0));
      chk("misalign_wen", bus.wb_wen, 0);
      run_instr(mk(0, 0, 2'd0, 3'd2, 32'h0, 5'd0, 0, 0, 0));
`endif

      // Mul/div left waiting, then reset: the instruction is abandoned.
      bus.ex_valid = 1; bus.kill_X = 0; bus.wb_src_sel_X = 2'd3; bus.rd_X = 5'd12; bus.wen_X = 1;
      bus.dmem_resp_valid = 0; bus.md_resp_valid = 0;
      @(posedge clk); #1;
      bus.ex_valid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("md_wait_stall", bus.stall_WB, 1);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      check_all_zero("md_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      bus.md_resp_valid = 1'b1; bus.md_resp_result = 32'hCAFE_F00D;
      #1;
      check_all_zero("late_md_resp");
      @(posedge clk); #1;
      chk("late_md_idle_retire", bus.retire, 0);
      chk("late_md_idle_stall", bus.stall_WB, 0);
      bus.md_resp_valid = 1'b0;

      for (int n = 0; n < 400; n++) begin
         in = mk(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                 $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) in.rd = 5'd0;
         run_instr(in);
      end
      run_instr(mk(0, 0, 2'd0, 3'd2, 32'h0, 5'd0, 0, 0, 0));
      @(posedge clk); #1;
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
